// File: rtl/eth_axis_pkg.sv
// Shared definitions for the 128-bit AXI4-Stream Ethernet datapath blocks.
package eth_axis_pkg;

    localparam int AXIS_DATA_W = 128;
    localparam int AXIS_KEEP_W = 16;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after start, wrapping.
module rr_pick #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] winner,
    output logic         found
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(start) + i) % N]) begin
                winner = W'((int'(start) + i) % N);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_axis_frame_arbiter_128b.sv
// Frame-atomic round-robin merge of N AXI4-Stream inputs into one registered
// output; each beat is tagged with its source port and frames are counted per port.
module eth_axis_frame_arbiter_128b
    import eth_axis_pkg::*;
#(
    parameter int N_PORTS  = 2,
    parameter int ID_WIDTH = $clog2(N_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORTS*AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [N_PORTS*AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic [N_PORTS-1:0]             s_axis_tvalid,
    output logic [N_PORTS-1:0]             s_axis_tready,
    input  logic [N_PORTS-1:0]             s_axis_tlast,
    output logic [AXIS_DATA_W-1:0]         m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0]         m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [ID_WIDTH-1:0]            m_axis_tid,
    output logic [N_PORTS*32-1:0]          frame_count
);

    arb_state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]         grant_q, grant_d;
    logic [ID_WIDTH-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]         tid_q, tid_d;
    logic [AXIS_DATA_W-1:0]      tdata_q, tdata_d;
    logic [AXIS_KEEP_W-1:0]      tkeep_q, tkeep_d;
    logic                        tvalid_q, tvalid_d;
    logic                        tlast_q, tlast_d;
    logic [N_PORTS-1:0][31:0]    frame_count_q, frame_count_d;

    logic [ID_WIDTH-1:0]         winner;
    logic                        found;
    logic                        out_free;
    logic                        accept;
    logic                        sel_last;

    rr_pick #(
        .N (N_PORTS),
        .W (ID_WIDTH)
    ) u_rr_pick (
        .req    (s_axis_tvalid),
        .start  (rr_ptr_q),
        .winner (winner),
        .found  (found)
    );

    assign out_free = !tvalid_q || m_axis_tready;
    assign sel_last = s_axis_tlast[grant_q];
    assign accept   = (state_q == ARB_LOCKED) && s_axis_tvalid[grant_q] && out_free;

    always_comb begin
        s_axis_tready = '0;
        if (state_q == ARB_LOCKED) begin
            s_axis_tready[grant_q] = out_free;
        end
    end

    // Next-state: arbitrate in IDLE, stream the granted frame in LOCKED.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        tid_d         = tid_q;
        tdata_d       = tdata_q;
        tkeep_d       = tkeep_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        frame_count_d = frame_count_q;

        if (accept) begin
            tdata_d  = s_axis_tdata[int'(grant_q)*AXIS_DATA_W +: AXIS_DATA_W];
            tkeep_d  = s_axis_tkeep[int'(grant_q)*AXIS_KEEP_W +: AXIS_KEEP_W];
            tlast_d  = sel_last;
            tid_d    = grant_q;
            tvalid_d = 1'b1;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (accept && sel_last) begin
                    frame_count_d[grant_q] = frame_count_q[grant_q] + 32'd1;
                    rr_ptr_d = (grant_q == ID_WIDTH'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Reset truncates any frame in flight: the output is dropped without tlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            tid_q         <= '0;
            tdata_q       <= '0;
            tkeep_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            tid_q         <= tid_d;
            tdata_q       <= tdata_d;
            tkeep_q       <= tkeep_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tid    = tid_q;
    assign frame_count   = frame_count_q;

endmodule
